// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 multiplier datapath: default widths and
// the product accumulator state encoding.
package mult_pkg;

  localparam int DEFAULT_PROD_W = 8;   // 4x4 multiplier product width
  localparam int DEFAULT_ACC_W  = 12;  // group sum width, wraps modulo 2^ACC_W
  localparam int DEFAULT_CNT_W  = 4;   // beat counter width, saturating

  typedef enum logic {
    ACCUM = 1'b0,  // collecting product beats
    DONE  = 1'b1   // holding a finished group until accepted
  } acc_state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products into groups closed by a last-tagged
// beat, then presents the registered sum, beat count and carry-out flag on
// an output handshake. One beat per cycle while accumulating.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = DEFAULT_PROD_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  acc_state_e       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_overflow;

  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_overflow_next;
  logic [CNT_W-1:0] w_count_next;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign w_sum_ext       = {1'b0, r_acc} + (ACC_W + 1)'(in_product);
  assign w_acc_next      = w_sum_ext[ACC_W-1:0];
  assign w_overflow_next = r_overflow | w_sum_ext[ACC_W];
  assign w_count_next    = (&r_count) ? r_count : r_count + 1'b1;

  // Ready is a pure state decode so no input reaches it combinationally.
  assign in_ready     = (r_state == ACCUM);
  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

  // Group FSM: accumulate beats, latch the result on last, hold until taken.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ACCUM;
      r_acc          <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else if (clr) begin
      // Abort: drop the partial group, any pending result and any beat now.
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              r_out_sum      <= w_acc_next;
              r_out_count    <= w_count_next;
              r_out_overflow <= w_overflow_next;
              r_out_valid    <= 1'b1;
              r_state        <= DONE;
              r_acc          <= '0;
              r_count        <= '0;
              r_overflow     <= 1'b0;
            end else begin
              r_acc      <= w_acc_next;
              r_count    <= w_count_next;
              r_overflow <= w_overflow_next;
            end
          end
        end
        DONE: begin
          // Result registers keep their values; only valid drops on accept.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a reference model pushes each
// finished group onto a queue, and a monitor pops and compares it when the
// output handshake occurs.
module tb_product_accumulator;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_product = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic [3:0]  out_count;
  logic        out_overflow;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model state for the group in progress.
  int   m_acc = 0;
  int   m_cnt = 0;
  bit   m_ovf = 1'b0;

  product_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Present one beat, wait (bounded) for ready, then update the model.
  task automatic send(input int prod, input bit last);
    int   waited = 0;
    exp_t e;
    in_valid   = 1'b1;
    in_product = prod[7:0];
    in_last    = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_acc = m_acc + prod;
    if (m_acc >= 4096) begin
      m_acc = m_acc - 4096;
      m_ovf = 1'b1;
    end
    if (m_cnt < 15) m_cnt++;
    if (last) begin
      e.sum = m_acc;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      sb_q.push_back(e);
      model_clear();
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: a handshake will occur at the coming edge.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_sum", 32'(out_sum), e.sum);
        check("sb_count", 32'(out_count), e.cnt);
        check("sb_overflow", 32'(out_overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    // Reset for two cycles, then look at the first cycle after release.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_overflow", 32'(out_overflow), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // Basic group: result valid one cycle after the last beat.
    send(225, 1'b0);
    send(225, 1'b0);
    send(225, 1'b1);
    check("basic_latency_valid", 32'(out_valid), 1);
    check("basic_done_in_ready", 32'(in_ready), 0);

    // Wrap and saturate: 19 beats of 225.
    for (int i = 0; i < 19; i++) send(225, i == 18);

    // Backpressure: result held stable, input stalled.
    cycle();
    out_ready = 1'b0;
    send(10, 1'b0);
    send(20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_sum", 32'(out_sum), 30);
      check("bp_out_count", 32'(out_count), 2);
      check("bp_in_ready", 32'(in_ready), 0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("bp_restart_in_ready", 32'(in_ready), 1);

    // Single-beat group of product 0.
    send(0, 1'b1);

    // Abort with clr: partial group and same-cycle beat are discarded.
    cycle();
    send(100, 1'b0);
    send(50, 1'b0);
    in_valid   = 1'b1;
    in_product = 8'd7;
    clr        = 1'b1;
    cycle();
    clr      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("clr_no_out_valid", 32'(out_valid), 0);
    check("clr_in_ready", 32'(in_ready), 1);
    send(5, 1'b1);

    // Same abort sequence using rst.
    cycle();
    send(100, 1'b0);
    send(50, 1'b0);
    in_valid   = 1'b1;
    in_product = 8'd7;
    rst        = 1'b1;
    cycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("rst_abort_no_out_valid", 32'(out_valid), 0);
    check("rst_abort_in_ready", 32'(in_ready), 1);
    send(5, 1'b1);

    // Drain: every expected result must have been observed.
    for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) cycle();
    check("sb_drained", 32'(sb_q.size()), 0);
    check("final_out_valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
